// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types for the data RAM port arbiter
package arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int LOCK_CNT_W = 8;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - {valid, owner} shift register that tracks reads in flight
module rd_tag_pipe
    import arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_valid,
    input  logic i_owner,
    output logic o_valid,
    output logic o_owner
);

    rd_tag_t [DEPTH-1:0] r_tag;
    rd_tag_t             w_in;

    assign w_in = '{valid: i_valid, owner: owner_t'(i_owner)};

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[DEPTH-2:0], w_in};
        end
    end

    assign o_valid = r_tag[DEPTH-1].valid;
    assign o_owner = r_tag[DEPTH-1].owner;

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the single-port data RAM between CPU and loader
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RAM_LAT  = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_stall,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    output logic              o_ldr_gnt,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata,
    input  logic              i_ldr_lock,
    output logic              o_ram_wea,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    localparam logic [LOCK_CNT_W-1:0] LP_MAX_LOCK = LOCK_CNT_W'(MAX_LOCK);

    arb_state_t             r_state, w_state_nxt;
    owner_t                 r_last, w_last_nxt;
    logic [LOCK_CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic                   r_ram_wea;
    logic [ADDR_W-1:0]      r_ram_addr;
    logic [DATA_W-1:0]      r_ram_din;

    logic                   w_contested;
    logic                   w_cpu_gnt, w_ldr_gnt, w_any_gnt;
    logic                   w_gnt_we;
    logic [ADDR_W-1:0]      w_gnt_addr;
    logic [DATA_W-1:0]      w_gnt_wdata;
    logic                   w_tag_valid, w_tag_owner;

    assign w_contested = i_cpu_req & i_ldr_req;

    always_comb begin
        w_cpu_gnt      = 1'b0;
        w_ldr_gnt      = 1'b0;
        w_state_nxt    = i_ldr_lock ? ST_LOCK : ST_ARB;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;

        if (!i_rst) begin
            if (w_contested) begin
                // In LOCK the CPU only gets through once the loader has used its bounded run
                if (r_state == ST_LOCK) begin
                    w_cpu_gnt = (r_lock_cnt >= LP_MAX_LOCK);
                end else begin
                    w_cpu_gnt = (r_last == OWN_LDR);
                end
                w_ldr_gnt = ~w_cpu_gnt;
            end else begin
                w_cpu_gnt = i_cpu_req;
                w_ldr_gnt = i_ldr_req;
            end
        end

        if (w_cpu_gnt) begin
            w_last_nxt     = OWN_CPU;
            w_lock_cnt_nxt = '0;
        end else if (w_ldr_gnt) begin
            w_last_nxt = OWN_LDR;
            if (w_contested && (r_state == ST_LOCK)) begin
                w_lock_cnt_nxt = r_lock_cnt + LOCK_CNT_W'(1);
            end
        end

        if (w_state_nxt == ST_ARB) begin
            w_lock_cnt_nxt = '0;
        end
    end

    assign w_any_gnt   = w_cpu_gnt | w_ldr_gnt;
    assign w_gnt_we    = w_ldr_gnt ? i_ldr_we    : i_cpu_we;
    assign w_gnt_addr  = w_ldr_gnt ? i_ldr_addr  : i_cpu_addr;
    assign w_gnt_wdata = w_ldr_gnt ? i_ldr_wdata : i_cpu_wdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_ARB;
            r_last     <= OWN_LDR;
            r_lock_cnt <= '0;
            r_ram_wea  <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_ram_wea  <= w_any_gnt & w_gnt_we;
            if (w_any_gnt) begin
                r_ram_addr <= w_gnt_addr;
                r_ram_din  <= w_gnt_wdata;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (1 + RAM_LAT)
    ) u_rd_tag_pipe (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_valid (w_any_gnt & ~w_gnt_we),
        .i_owner (w_ldr_gnt),
        .o_valid (w_tag_valid),
        .o_owner (w_tag_owner)
    );

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_ldr_gnt    = w_ldr_gnt;
    assign o_cpu_stall  = i_cpu_req & ~w_cpu_gnt;
    assign o_cpu_rvalid = w_tag_valid & ~w_tag_owner & ~i_rst;
    assign o_ldr_rvalid = w_tag_valid &  w_tag_owner & ~i_rst;
    assign o_cpu_rdata  = i_ram_dout;
    assign o_ldr_rdata  = i_ram_dout;
    assign o_ram_wea    = r_ram_wea;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_din    = r_ram_din;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int MAXL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] cpu_addr, ldr_addr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [DW-1:0] cpu_rdata, ldr_rdata;
    logic          ram_wea;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .MAX_LOCK(MAXL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
        .o_ldr_gnt(ldr_gnt), .o_ldr_rvalid(ldr_rvalid), .o_ldr_rdata(ldr_rdata),
        .i_ldr_lock(ldr_lock),
        .o_ram_wea(ram_wea), .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {24'h0, a});
    endfunction

    // Single-port RAM, one-cycle registered read
    bit [31:0] mem [256];
    bit        mem_w [256];
    always @(posedge clk) begin
        ram_dout <= mem_w[ram_addr[7:0]] ? mem[ram_addr[7:0]] : init_val(ram_addr[7:0]);
        if (ram_wea) begin
            mem[ram_addr[7:0]]   <= ram_din;
            mem_w[ram_addr[7:0]] <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: arbitration rules, expected RAM port, expected read returns
    typedef struct {
        int          own;
        logic [31:0] data;
        int          due;
    } rd_t;

    bit          m_lock = 1'b0;
    int          m_last = 1;
    int          m_cnt  = 0;
    logic        m_wea  = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_din  = '0;
    bit   [31:0] e_mem [256];
    bit          e_w [256];
    rd_t         q [$];
    int          glog [$];
    int          rvlog [$];
    logic [31:0] rvdata [$];
    int          cyc = 0;

    always @(negedge clk) begin : cmp
        bit          ec, el, con, ev_c, ev_l, we;
        logic [31:0] ed, a, d;
        rd_t         e;
        cyc++;
        con = cpu_req && ldr_req;
        ec  = 1'b0;
        el  = 1'b0;
        if (!rst) begin
            if (con) begin
                ec = m_lock ? (m_cnt == MAXL) : (m_last == 1);
                el = !ec;
            end else begin
                ec = cpu_req;
                el = ldr_req;
            end
        end
        chk($sformatf("cpu_gnt@%0d", cyc), cpu_gnt, ec);
        chk($sformatf("ldr_gnt@%0d", cyc), ldr_gnt, el);
        chk($sformatf("cpu_stall@%0d", cyc), cpu_stall, cpu_req && !ec);
        chk($sformatf("ram_wea@%0d", cyc), ram_wea, m_wea);
        chk($sformatf("ram_addr@%0d", cyc), ram_addr, m_addr);
        chk($sformatf("ram_din@%0d", cyc), ram_din, m_din);

        ev_c = 1'b0;
        ev_l = 1'b0;
        ed   = '0;
        if (!rst && q.size() > 0 && q[0].due == cyc) begin
            e    = q.pop_front();
            ev_c = (e.own == 0);
            ev_l = (e.own == 1);
            ed   = e.data;
        end
        chk($sformatf("cpu_rvalid@%0d", cyc), cpu_rvalid, ev_c);
        chk($sformatf("ldr_rvalid@%0d", cyc), ldr_rvalid, ev_l);
        if (ev_c) chk($sformatf("cpu_rdata@%0d", cyc), cpu_rdata, ed);
        if (ev_l) chk($sformatf("ldr_rdata@%0d", cyc), ldr_rdata, ed);

        if (cpu_gnt) glog.push_back(0);
        else if (ldr_gnt) glog.push_back(1);
        if (cpu_rvalid) begin rvlog.push_back(0); rvdata.push_back(cpu_rdata); end
        if (ldr_rvalid) begin rvlog.push_back(1); rvdata.push_back(ldr_rdata); end

        if (rst) begin
            m_lock = 1'b0;
            m_last = 1;
            m_cnt  = 0;
            m_wea  = 1'b0;
            m_addr = '0;
            m_din  = '0;
            q.delete();
        end else begin
            if (ec || el) begin
                we = ec ? cpu_we : ldr_we;
                a  = ec ? cpu_addr : ldr_addr;
                d  = ec ? cpu_wdata : ldr_wdata;
                m_wea  = we;
                m_addr = a;
                m_din  = d;
                if (we) begin
                    e_mem[a[7:0]] = d;
                    e_w[a[7:0]]   = 1'b1;
                end else begin
                    q.push_back('{own: (el ? 1 : 0),
                                  data: (e_w[a[7:0]] ? e_mem[a[7:0]] : init_val(a[7:0])),
                                  due: cyc + 1 + LAT});
                end
                if (ec) m_cnt = 0;
                else if (con && m_lock) m_cnt++;
                m_last = ec ? 0 : 1;
            end else begin
                m_wea = 1'b0;
            end
            if (!ldr_lock) m_cnt = 0;
            m_lock = ldr_lock;
        end
    end

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    function automatic int rl(input int i);
        return (i < rvlog.size()) ? rvlog[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, r0;
        rst = 1'b1; ldr_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; cpu_wdata = '0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h31; ldr_wdata = '0;
        repeat (3) tick();
        settle();
        chk("reset_cpu_gnt", cpu_gnt, 1'b0);
        chk("reset_ldr_gnt", ldr_gnt, 1'b0);
        chk("reset_ram_wea", ram_wea, 1'b0);
        chk("reset_ram_addr", ram_addr, 32'h0);
        chk("reset_ram_din", ram_din, 32'h0);
        chk("reset_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);

        // Contention in ARB straight after reset
        tick();
        rst = 1'b0;
        m = glog.size();
        repeat (4) tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (4) tick();
        chk("arb_count", glog.size() - m, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("arb_seq%0d", i), gl(m + i), i % 2);

        // CPU-only read of 0xDEADBEEF at 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        settle();
        chk("t1_gnt", cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("t1_ram_addr", ram_addr, 32'h10);
        chk("t1_ram_wea", ram_wea, 1'b0);
        chk("t1_early_rvalid", cpu_rvalid, 1'b0);
        tick();
        settle();
        chk("t1_rvalid", cpu_rvalid, 1'b1);
        chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Loader write then CPU read of the same address
        r0 = rvlog.size();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h0000_1234;
        tick();
        ldr_req = 1'b0; ldr_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick();
        cpu_req = 1'b0;
        repeat (4) tick();
        chk("t4_rv_count", rvlog.size() - r0, 1);
        chk("t4_rv_owner", rl(r0), 0);
        chk("t4_rdata", (rvdata.size() > r0) ? rvdata[r0] : 32'hX, 32'h0000_1234);

        // Lock bound
        ldr_lock = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        ldr_req = 1'b1; ldr_we = 1'b0;
        m = glog.size();
        for (int i = 0; i < 17; i++) begin
            ldr_addr = 32'h41 + i;
            tick();
        end
        cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
        repeat (4) tick();
        chk("lock_count", glog.size() - m, 17);
        for (int i = 0; i < 17; i++) chk($sformatf("lock_seq%0d", i), gl(m + i), (i == 8) ? 0 : 1);

        // Alternating back-to-back reads
        r0 = rvlog.size();
        for (int i = 0; i < 6; i++) begin
            cpu_req = (i % 2 == 0); ldr_req = (i % 2 != 0);
            cpu_we = 1'b0; ldr_we = 1'b0;
            cpu_addr = 32'h50 + i; ldr_addr = 32'h50 + i;
            tick();
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (4) tick();
        chk("stream_count", rvlog.size() - r0, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stream_owner%0d", i), rl(r0 + i), i % 2);
            chk($sformatf("stream_data%0d", i), (rvdata.size() > r0 + i) ? rvdata[r0 + i] : 32'hX,
                init_val(8'h50 + 8'(i)));
        end

        // Reset while a CPU read is in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        settle();
        chk("t5_gnt", cpu_gnt, 1'b1);
        tick();
        r0 = rvlog.size();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h0BAD;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h61;
        m = glog.size();
        settle();
        chk("t5_rst_gnt", {cpu_gnt, ldr_gnt}, 2'b00);
        tick();
        rst = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h62;
        settle();
        chk("t5_post_gnt", cpu_gnt, 1'b1);
        chk("t5_ram_wea", ram_wea, 1'b0);
        chk("t5_no_old_rvalid", cpu_rvalid, 1'b0);
        tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (4) tick();
        chk("t5_first_owner", gl(m), 0);
        chk("t5_rv_count", rvlog.size() - r0, 1);
        chk("t5_rv_data", (rvdata.size() > r0) ? rvdata[r0] : 32'hX, init_val(8'h62));
        chk("t5_no_write", mem_w[8'h60], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
